// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding and control-bit positions
// used by the arbiter and the bus master unit.
package bus_pkg;

   typedef enum logic [3:0] {
      PARK     = 4'b0001,
      GRANT    = 4'b0010,
      WAIT_RSP = 4'b0100,
      TURN     = 4'b1000
   } arb_state_t;

   localparam int CTRL_W         = 2;
   localparam int CTRL_RNW_BIT   = 1;
   localparam int CTRL_VALID_BIT = 0;

endpackage

// File: rtl/bus_if.sv
// Shared tri-state bus. Each agent contributes a drive through its own enable;
// the wires resolve here so drivers never meet across module boundaries.
interface bus_if
   import bus_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);

   wire [ADDR_W-1:0] address;
   wire [DATA_W-1:0] data;
   wire [CTRL_W-1:0] control;

   // arbiter parks the bus at zero while nobody owns it
   logic park_drive;

   logic              agent_oe;
   logic [ADDR_W-1:0] agent_address;
   logic [DATA_W-1:0] agent_data;
   logic [CTRL_W-1:0] agent_control;

   assign address = park_drive ? '0 : 'z;
   assign data    = park_drive ? '0 : 'z;
   assign control = park_drive ? '0 : 'z;

   assign address = agent_oe ? agent_address : 'z;
   assign data    = agent_oe ? agent_data    : 'z;
   assign control = agent_oe ? agent_control : 'z;

   modport arbiter (output park_drive, input control);

   modport master (
      output agent_oe, agent_address, agent_data, agent_control,
      input  address, data, control
   );

   modport slave (
      output agent_oe, agent_address, agent_data, agent_control,
      input  address, data, control
   );

endinterface

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around the master count.
module bus_arb_rr_pick #(
   parameter  int NUM_MASTERS = 4,
   localparam int PW = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [PW-1:0]          ptr,
   output logic [PW-1:0]          winner,
   output logic                   valid
);

   localparam int SW = PW + 1;

   logic [PW-1:0]          cand [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] hit;

   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
      logic [SW-1:0] sum;
      assign sum       = {1'b0, ptr} + SW'(gi);
      assign cand[gi]  = (sum >= SW'(NUM_MASTERS)) ? PW'(sum - SW'(NUM_MASTERS)) : sum[PW-1:0];
      assign hit[gi]   = req[cand[gi]];
   end

   // scan from the far end so the candidate closest to ptr wins
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            winner = cand[i];
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with parked bus, turnaround cycle and per-transaction
// timeout on both the master strobe and the slave response.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter  int NUM_MASTERS    = 4,
   parameter  int TIMEOUT_CYCLES = 16,
   localparam int PW = $clog2(NUM_MASTERS),
   localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                   clk,
   input  logic                   n_rst,
   bus_if.arbiter                 bus,
   input  logic [NUM_MASTERS-1:0] req,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic                   busy,
   output logic                   bus_error,
   output logic [PW-1:0]          err_id
);

   arb_state_t             state_reg, state_next;
   logic [NUM_MASTERS-1:0] gnt_reg, gnt_next;
   logic [PW-1:0]          ptr_reg, ptr_next;
   logic [PW-1:0]          owner_reg, owner_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic                   bus_error_reg, bus_error_next;
   logic [PW-1:0]          err_id_reg, err_id_next;
   logic                   armed_reg;

   logic [PW-1:0] pick_winner;
   logic          pick_valid;
   logic          strobe;
   logic          rnw;
   logic          timed_out;
   logic          owner_req;

   bus_arb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
      .req    (req),
      .ptr    (ptr_reg),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   assign strobe    = bus.control[CTRL_VALID_BIT];
   assign rnw       = bus.control[CTRL_RNW_BIT];
   assign timed_out = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
   assign owner_req = |(req & gnt_reg);

   always_comb begin
      state_next     = state_reg;
      gnt_next       = gnt_reg;
      ptr_next       = ptr_reg;
      owner_next     = owner_reg;
      cnt_next       = cnt_reg;
      bus_error_next = 1'b0;
      err_id_next    = err_id_reg;
      case (state_reg)
         PARK: begin
            // armed_reg holds off the very first edge after reset release
            if (armed_reg && pick_valid) begin
               state_next = GRANT;
               gnt_next   = NUM_MASTERS'(1) << pick_winner;
               owner_next = pick_winner;
               ptr_next   = (pick_winner == PW'(NUM_MASTERS - 1)) ? '0 : PW'(pick_winner + 1'b1);
               cnt_next   = '0;
            end
         end
         GRANT: begin
            if (strobe && rnw) begin
               state_next = WAIT_RSP;
               cnt_next   = '0;
            end else if (strobe || !owner_req) begin
               state_next = TURN;
               gnt_next   = '0;
            end else if (timed_out) begin
               state_next     = TURN;
               gnt_next       = '0;
               bus_error_next = 1'b1;
               err_id_next    = owner_reg;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_RSP: begin
            if (strobe) begin
               state_next = TURN;
               gnt_next   = '0;
            end else if (timed_out) begin
               state_next     = TURN;
               gnt_next       = '0;
               bus_error_next = 1'b1;
               err_id_next    = owner_reg;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         TURN: begin
            state_next = PARK;
         end
         default: begin
            state_next = PARK;
            gnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg     <= PARK;
         gnt_reg       <= '0;
         ptr_reg       <= '0;
         owner_reg     <= '0;
         cnt_reg       <= '0;
         bus_error_reg <= 1'b0;
         err_id_reg    <= '0;
         armed_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         gnt_reg       <= gnt_next;
         ptr_reg       <= ptr_next;
         owner_reg     <= owner_next;
         cnt_reg       <= cnt_next;
         bus_error_reg <= bus_error_next;
         err_id_reg    <= err_id_next;
         armed_reg     <= 1'b1;
      end
   end

   assign bus.park_drive = (state_reg == PARK);
   assign gnt            = gnt_reg;
   assign busy           = (state_reg != PARK);
   assign bus_error      = bus_error_reg;
   assign err_id         = err_id_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transactions checked against a round-robin / timeout reference model.
module tb_bus_arbiter;
   import bus_pkg::*;

   localparam int N = 4;
   localparam int T = 16;

   logic         clk = 1'b0;
   logic         n_rst;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic         busy;
   logic         bus_error;
   logic [1:0]   err_id;

   int n_checks   = 0;
   int n_pass     = 0;
   int model_ptr  = 0;
   int exp_err_id = 0;

   bus_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .bus       (bus),
      .req       (req),
      .gnt       (gnt),
      .busy      (busy),
      .bus_error (bus_error),
      .err_id    (err_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_on(input logic rnw);
      bus.agent_oe      = 1'b1;
      bus.agent_control = {rnw, 1'b1};
      bus.agent_address = 16'($urandom);
      bus.agent_data    = $urandom;
   endtask

   task automatic strobe_off();
      bus.agent_oe      = 1'b0;
      bus.agent_control = '0;
   endtask

   // Reference rule: first requester at index >= ptr, wrapping modulo N
   function automatic int model_pick(input logic [N-1:0] r);
      for (int i = 0; i < N; i++)
         if (r[(model_ptr + i) % N]) return (model_ptr + i) % N;
      return 0;
   endfunction

   task automatic apply_reset();
      req = '0;
      strobe_off();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      tick();
      model_ptr  = 0;
      exp_err_id = 0;
   endtask

   // kind: 0 write, 1 read with response after w wait cycles, 2 read no response,
   //       3 master drops req at GRANT cycle g, 4 master never strobes
   task automatic run_txn(input logic [N-1:0] r, input int kind, input int g, input int w, input bit scramble);
      int           win;
      logic [N-1:0] oh;
      bit           own;
      bit           to_wait;
      req = r;
      win = model_pick(r);
      oh  = '0;
      oh[win] = 1'b1;
      model_ptr = (win + 1) % N;
      tick();
      n_checks++; if (gnt !== oh || busy !== 1'b1) $display("FAIL grant: gnt=%b busy=%b, required gnt=%b busy=1", gnt, busy, oh); else n_pass++;
      own = 1'b1;
      to_wait = 1'b0;
      for (int c = 0; c < T; c++) begin
         if (scramble) req = (own ? oh : '0) | (N'($urandom) & ~oh);
         if (c == g) begin
            case (kind)
               0:       strobe_on(1'b0);
               1, 2:    strobe_on(1'b1);
               3:       begin own = 1'b0; req = req & ~oh; end
               default: ;
            endcase
         end
         tick();
         strobe_off();
         if (c == g && kind != 4) begin
            if (kind == 1 || kind == 2) begin
               n_checks++; if (gnt !== oh || bus_error !== 1'b0) $display("FAIL read_accept: gnt=%b err=%b, required gnt=%b err=0", gnt, bus_error, oh); else n_pass++;
               to_wait = 1'b1;
            end else begin
               n_checks++; if (gnt !== '0 || bus_error !== 1'b0) $display("FAIL grant_end: gnt=%b err=%b, required gnt=0 err=0", gnt, bus_error); else n_pass++;
            end
            break;
         end
         if (c == T - 1) begin
            n_checks++; if (bus_error !== 1'b1 || gnt !== '0 || err_id !== 2'(win)) $display("FAIL grant_timeout: err=%b gnt=%b id=%0d, required err=1 gnt=0 id=%0d", bus_error, gnt, err_id, win); else n_pass++;
            exp_err_id = win;
            break;
         end
         n_checks++; if (gnt !== oh || bus_error !== 1'b0) $display("FAIL grant_hold: gnt=%b err=%b, required gnt=%b err=0", gnt, bus_error, oh); else n_pass++;
      end
      if (to_wait) begin
         for (int c = 0; c < T; c++) begin
            if (scramble) req = oh | (N'($urandom) & ~oh);
            if (c == w) strobe_on(1'b0);
            tick();
            strobe_off();
            if (c == w) begin
               n_checks++; if (gnt !== '0 || bus_error !== 1'b0) $display("FAIL rsp_end: gnt=%b err=%b, required gnt=0 err=0", gnt, bus_error); else n_pass++;
               break;
            end
            if (c == T - 1) begin
               n_checks++; if (bus_error !== 1'b1 || gnt !== '0 || err_id !== 2'(win)) $display("FAIL rsp_timeout: err=%b gnt=%b id=%0d, required err=1 gnt=0 id=%0d", bus_error, gnt, err_id, win); else n_pass++;
               exp_err_id = win;
               break;
            end
            n_checks++; if (gnt !== oh || bus_error !== 1'b0) $display("FAIL rsp_hold: gnt=%b err=%b, required gnt=%b err=0", gnt, bus_error, oh); else n_pass++;
         end
      end
      n_checks++; if (busy !== 1'b1 || gnt !== '0) $display("FAIL turn: busy=%b gnt=%b, required busy=1 gnt=0", busy, gnt); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b0 || gnt !== '0 || bus_error !== 1'b0 || bus.control !== 2'b00) $display("FAIL park: busy=%b gnt=%b err=%b ctl=%b, required 0 0 0 00", busy, gnt, bus_error, bus.control); else n_pass++;
      n_checks++; if (err_id !== 2'(exp_err_id)) $display("FAIL err_id_hold: id=%0d, required %0d", err_id, exp_err_id); else n_pass++;
      $display("txn master=%0d kind=%0d g=%0d w=%0d err_id=%0d", win, kind, g, w, err_id);
   endtask

   task automatic test_reset();
      req = '0;
      strobe_off();
      n_rst = 1'b0;
      tick();
      tick();
      n_checks++; if (gnt !== '0 || busy !== 1'b0 || bus_error !== 1'b0 || err_id !== 2'd0) $display("FAIL reset_state: gnt=%b busy=%b err=%b id=%0d, required all zero", gnt, busy, bus_error, err_id); else n_pass++;
      n_checks++; if (bus.control !== 2'b00 || bus.address !== 16'h0 || bus.data !== 32'h0) $display("FAIL reset_park: ctl=%b addr=%h data=%h, required zeros", bus.control, bus.address, bus.data); else n_pass++;
      n_rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++; if (gnt !== '0 || busy !== 1'b0 || bus.control !== 2'b00 || bus.address !== 16'h0) $display("FAIL idle_park: gnt=%b busy=%b ctl=%b addr=%h, required zeros", gnt, busy, bus.control, bus.address); else n_pass++;
      end
      model_ptr  = 0;
      exp_err_id = 0;
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 0, 0, 1'b0);
   endtask

   task automatic test_read_response();
      apply_reset();
      run_txn(4'b0100, 1, 0, 4, 1'b0);
   endtask

   task automatic test_read_timeout();
      apply_reset();
      run_txn(4'b0010, 2, 0, T, 1'b0);
   endtask

   task automatic test_timeout_boundary();
      run_txn(4'b1000, 1, 0, T - 1, 1'b0);
      run_txn(4'b0001, 0, T - 1, 0, 1'b0);
   endtask

   task automatic test_drop_and_idle();
      run_txn(4'b0100, 3, 2, 0, 1'b0);
      run_txn(4'b1010, 4, T, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int           win;
      logic [N-1:0] oh;
      apply_reset();
      run_txn(4'b1111, 0, 0, 0, 1'b0);
      req = 4'b0110;
      win = model_pick(req);
      oh  = '0;
      oh[win] = 1'b1;
      tick();
      strobe_on(1'b1);
      tick();
      strobe_off();
      tick();
      tick();
      n_checks++; if (gnt !== oh || busy !== 1'b1) $display("FAIL mid_wait: gnt=%b busy=%b, required gnt=%b busy=1", gnt, busy, oh); else n_pass++;
      n_rst = 1'b0;
      #1;
      n_checks++; if (gnt !== '0 || busy !== 1'b0 || bus.control !== 2'b00) $display("FAIL async_reset: gnt=%b busy=%b ctl=%b, required 0 0 00", gnt, busy, bus.control); else n_pass++;
      req = 4'b1111;
      tick();
      n_rst = 1'b1;
      model_ptr  = 0;
      exp_err_id = 0;
      tick();
      n_checks++; if (gnt !== '0) $display("FAIL first_edge: gnt=%b, required 0", gnt); else n_pass++;
      run_txn(4'b1111, 0, 1, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      int           kind;
      int           g;
      int           w;
      for (int i = 0; i < 40; i++) begin
         r    = N'($urandom_range(1, (1 << N) - 1));
         kind = $urandom_range(0, 4);
         g    = (kind == 4) ? T : $urandom_range(0, T - 1);
         w    = (kind == 2) ? T : $urandom_range(0, T - 1);
         run_txn(r, kind, g, w, 1'b1);
      end
   endtask

   initial begin
      bus.agent_oe      = 1'b0;
      bus.agent_address = '0;
      bus.agent_data    = '0;
      bus.agent_control = '0;
      req   = '0;
      n_rst = 1'b0;
      test_reset();
      test_round_robin();
      test_read_response();
      test_read_timeout();
      test_timeout_boundary();
      test_drop_and_idle();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
